// File: rtl/memory_loader_if.sv
// ---------------------------------------------------------------------------
// memory_loader_if
//   Bundles the CPU memory port and the byte-loader port of memory_loader.
//
//   CPU side : mem_we, mem_addr, mem_data (to memory), mem_in (read data)
//   Loader   : ld_valid, ld_byte, ld_last, ld_start (to memory), ld_ready
//   Control  : cpu_run (memory -> CPU reset release)
//
//   master : the CPU/loader side that drives requests
//   slave  : the memory_loader block
// ---------------------------------------------------------------------------
interface memory_loader_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
);
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] mem_in;
    logic                  ld_valid;
    logic [7:0]            ld_byte;
    logic                  ld_last;
    logic                  ld_ready;
    logic                  ld_start;
    logic                  cpu_run;

    modport master (
        output mem_we, mem_addr, mem_data, ld_valid, ld_byte, ld_last, ld_start,
        input  mem_in, ld_ready, cpu_run
    );

    modport slave (
        input  mem_we, mem_addr, mem_data, ld_valid, ld_byte, ld_last, ld_start,
        output mem_in, ld_ready, cpu_run
    );
endinterface

// File: rtl/memory_loader.sv
// ---------------------------------------------------------------------------
// memory_loader
//   Word memory that is first filled from a byte stream (high byte first,
//   starting at LOAD_BASE) and then handed over to a CPU. While loading, the
//   CPU is held in reset (cpu_run=0); once the image is complete the CPU gets
//   a read-first, one-cycle-latency read/write port. ld_start in RUN reloads.
//
//   Ports:
//     clk   : clock, all state changes on posedge
//     rst_n : asynchronous active-low reset (array contents are kept)
//     bus   : memory_loader_if.slave (CPU port, loader port, cpu_run)
// ---------------------------------------------------------------------------
module memory_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int LOAD_BASE  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    memory_loader_if.slave     bus
);
    typedef enum logic [1:0] {
        LOAD_HI,
        LOAD_LO,
        RUN
    } state_t;

    localparam int                  DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PTR_BASE = ADDR_WIDTH'(LOAD_BASE);
    localparam logic [ADDR_WIDTH-1:0] PTR_MAX  = {ADDR_WIDTH{1'b1}};

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   ptr_reg, ptr_next;
    logic [7:0]              hi_byte_reg, hi_byte_next;
    logic                    armed_reg;
    logic                    cpu_run_reg;
    logic [DATA_WIDTH-1:0]   mem_in_reg;

    logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

    logic                    xfer;
    logic                    ld_we;
    logic [DATA_WIDTH-1:0]   ld_wdata;
    logic                    cpu_we;

    // armed_reg stays low until the first edge after reset release, so the
    // release edge itself can never accept a byte.
    assign bus.ld_ready = armed_reg && (state_reg != RUN);
    assign bus.cpu_run  = cpu_run_reg;
    assign bus.mem_in   = mem_in_reg;

    assign xfer   = bus.ld_valid && bus.ld_ready;
    assign cpu_we = (state_reg == RUN) && bus.mem_we;

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        hi_byte_next = hi_byte_reg;
        ld_we        = 1'b0;
        ld_wdata     = DATA_WIDTH'({hi_byte_reg, bus.ld_byte});

        case (state_reg)
            LOAD_HI: begin
                if (xfer) begin
                    if (bus.ld_last) begin
                        // Odd-length image: pad the final word's low byte.
                        ld_we      = 1'b1;
                        ld_wdata   = DATA_WIDTH'({bus.ld_byte, 8'h00});
                        state_next = RUN;
                    end else begin
                        hi_byte_next = bus.ld_byte;
                        state_next   = LOAD_LO;
                    end
                end
            end
            LOAD_LO: begin
                if (xfer) begin
                    ld_we = 1'b1;
                    if (ptr_reg != PTR_MAX) begin
                        ptr_next = ptr_reg + 1'b1;
                    end
                    // Top word written: memory is full, hand over to the CPU.
                    if (bus.ld_last || (ptr_reg == PTR_MAX)) begin
                        state_next = RUN;
                    end else begin
                        state_next = LOAD_HI;
                    end
                end
            end
            RUN: begin
                if (bus.ld_start) begin
                    state_next = LOAD_HI;
                    ptr_next   = PTR_BASE;
                end
            end
            default: begin
                state_next = LOAD_HI;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= LOAD_HI;
            ptr_reg     <= PTR_BASE;
            hi_byte_reg <= 8'h00;
            armed_reg   <= 1'b0;
            cpu_run_reg <= 1'b0;
            mem_in_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            hi_byte_reg <= hi_byte_next;
            armed_reg   <= 1'b1;
            cpu_run_reg <= (state_next == RUN);
            // Read-first: picks up the pre-write word on a same-address write.
            if (state_reg == RUN) begin
                mem_in_reg <= mem[bus.mem_addr];
            end
        end
    end

    // Array has no reset so an image survives a CPU reset. Loader and CPU
    // writes are mutually exclusive by state.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ptr_reg] <= ld_wdata;
        end else if (cpu_we) begin
            mem[bus.mem_addr] <= bus.mem_data;
        end
    end
endmodule

// File: tb/tb_memory_loader.sv
// ---------------------------------------------------------------------------
// tb_memory_loader
//   Directed bench for memory_loader. CPU reads push their expected word into
//   a scoreboard queue when the address is driven and are popped and compared
//   when mem_in is produced one cycle later.
// ---------------------------------------------------------------------------
module tb_memory_loader;
    logic clk;
    logic rst_n;

    memory_loader_if #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) bus ();

    memory_loader #(
        .ADDR_WIDTH (6),
        .DATA_WIDTH (16),
        .LOAD_BASE  (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [15:0] sb_exp_q [$];
    string       sb_tag_q [$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after posedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        bus.ld_valid = 1'b1;
        bus.ld_byte  = b;
        bus.ld_last  = last;
        while (!bus.ld_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("ld_ready_timeout", 16'(bus.ld_ready), 16'd1);
        step();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic cpu_read(input logic [5:0] a, input logic [15:0] exp, input string tag);
        bus.mem_we   = 1'b0;
        bus.mem_addr = a;
        sb_exp_q.push_back(exp);
        sb_tag_q.push_back(tag);
        step();
        $display("read  addr %0d -> %h", a, bus.mem_in);
        check(sb_tag_q.pop_front(), bus.mem_in, sb_exp_q.pop_front());
    endtask

    // Write and read the same address in one cycle; exp_old is the prior word.
    task automatic cpu_write(input logic [5:0] a, input logic [15:0] d,
                             input logic [15:0] exp_old, input string tag);
        bus.mem_we   = 1'b1;
        bus.mem_addr = a;
        bus.mem_data = d;
        sb_exp_q.push_back(exp_old);
        sb_tag_q.push_back(tag);
        step();
        bus.mem_we = 1'b0;
        $display("write addr %0d <- %h (read back %h)", a, d, bus.mem_in);
        check(sb_tag_q.pop_front(), bus.mem_in, sb_exp_q.pop_front());
    endtask

    task automatic cpu_write_only(input logic [5:0] a, input logic [15:0] d);
        bus.mem_we   = 1'b1;
        bus.mem_addr = a;
        bus.mem_data = d;
        step();
        bus.mem_we = 1'b0;
        $display("write addr %0d <- %h", a, d);
    endtask

    task automatic pulse_start();
        bus.ld_start = 1'b1;
        step();
        bus.ld_start = 1'b0;
        $display("ld_start");
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_data = '0;
        bus.ld_valid = 1'b0;
        bus.ld_byte  = '0;
        bus.ld_last  = 1'b0;
        bus.ld_start = 1'b0;

        // Reset state
        repeat (2) step();
        check("rst_mem_in", bus.mem_in, 16'h0000);
        check("rst_cpu_run", 16'(bus.cpu_run), 16'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_ld_ready", 16'(bus.ld_ready), 16'd1);
        check("post_rst_cpu_run", 16'(bus.cpu_run), 16'd0);

        // Basic four-byte image
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b0);
        check("mid_load_cpu_run", 16'(bus.cpu_run), 16'd0);
        send_byte(8'h78, 1'b1);
        check("load_done_cpu_run", 16'(bus.cpu_run), 16'd1);
        check("load_done_ld_ready", 16'(bus.ld_ready), 16'd0);
        cpu_read(6'd8, 16'h1234, "rd_8");
        cpu_read(6'd9, 16'h5678, "rd_9");

        // CPU write then read back
        cpu_write_only(6'd20, 16'hBEEF);
        cpu_read(6'd20, 16'hBEEF, "rd_20");

        // Read-first on same-address write
        cpu_write(6'd8, 16'h0001, 16'h1234, "rw_same_old");
        cpu_read(6'd8, 16'h0001, "rw_same_new");

        // Seed low words that the loader must not touch
        for (int i = 0; i < 8; i++) cpu_write_only(6'(i), 16'hA000 + 16'(i));

        // Reload coinciding with a CPU write to addr 2
        bus.mem_we   = 1'b1;
        bus.mem_addr = 6'd2;
        bus.mem_data = 16'h3030;
        pulse_start();
        check("start_cpu_run", 16'(bus.cpu_run), 16'd0);
        check("start_ld_ready", 16'(bus.ld_ready), 16'd1);
        check("start_mem_in", bus.mem_in, 16'hA002);

        // CPU write during load is ignored (addr 1 held at A001)
        bus.mem_we   = 1'b1;
        bus.mem_addr = 6'd1;
        bus.mem_data = 16'hFFFF;

        // Full load: 56 words, 112 bytes, no ld_last
        for (int k = 0; k < 56; k++) begin
            send_byte(8'(k), 1'b0);
            bus.mem_we = 1'b0;
            if (k == 55) check("full_before_last_cpu_run", 16'(bus.cpu_run), 16'd0);
            send_byte(~8'(k), 1'b0);
        end
        check("full_cpu_run", 16'(bus.cpu_run), 16'd1);
        check("full_ld_ready", 16'(bus.ld_ready), 16'd0);
        check("load_hold_mem_in", bus.mem_in, 16'hA002);
        for (int i = 0; i < 8; i++)
            cpu_read(6'(i), (i == 2) ? 16'h3030 : 16'hA000 + 16'(i), "rd_low_kept");
        cpu_read(6'd8, 16'h00FF, "rd_full_8");
        cpu_read(6'd40, 16'h20DF, "rd_full_40");
        cpu_read(6'd63, 16'h37C8, "rd_full_63");

        // ld_last on a high byte
        pulse_start();
        send_byte(8'hAB, 1'b1);
        check("odd_cpu_run", 16'(bus.cpu_run), 16'd1);
        cpu_read(6'd8, 16'hAB00, "rd_odd_8");
        cpu_read(6'd9, 16'h01FE, "rd_odd_9");

        // Reset mid-load after one high byte, then reload with gaps
        pulse_start();
        send_byte(8'h77, 1'b0);
        rst_n = 1'b0;
        step();
        check("midrst_mem_in", bus.mem_in, 16'h0000);
        check("midrst_cpu_run", 16'(bus.cpu_run), 16'd0);
        rst_n = 1'b1;
        step();
        check("midrst_ld_ready", 16'(bus.ld_ready), 16'd1);
        send_byte(8'h11, 1'b0);
        repeat (3) step();
        check("stall_ld_ready", 16'(bus.ld_ready), 16'd1);
        check("stall_cpu_run", 16'(bus.cpu_run), 16'd0);
        send_byte(8'h22, 1'b1);
        check("reload_cpu_run", 16'(bus.cpu_run), 16'd1);
        cpu_read(6'd8, 16'h1122, "rd_reload_8");
        cpu_read(6'd9, 16'h01FE, "rd_reload_9");
        cpu_read(6'd63, 16'h37C8, "rd_reload_63");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end
endmodule
